serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 4, giving operand width in bits (minimum 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled on rising clk.
REQ-005 SHALL have port A  input  INPUT_WIDTH  minuend, unsigned, sampled on the accepted start.
REQ-006 SHALL have port B  input  INPUT_WIDTH  subtrahend, unsigned, sampled on the accepted start.
REQ-007 SHALL have port Diff  output  INPUT_WIDTH+1  registered result A-B, two's complement.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new Diff value.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE, capturing A and B into internal shift registers, clearing the borrow flag and the bit counter, and entering RUN.
REQ-012 SHALL ignore start while in RUN, leaving the operands, the counter and Diff unaffected.
REQ-013 SHALL process one bit per clock in RUN, LSB first: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-014 SHALL shift each d into an internal result register from the MSB end and register bout as the next bin.
REQ-015 SHALL leave RUN after exactly INPUT_WIDTH bit-cycles; entry to DONE loads Diff = {final borrow, result}.
REQ-016 SHALL therefore give fixed latency: start accepted at edge k, done high in the cycle after edge k+INPUT_WIDTH.
REQ-017 SHALL treat the Diff MSB as the sign bit, equal to 1 exactly when A < B.
REQ-018 SHALL drive busy high if and only if state is RUN.
REQ-019 SHALL drive done high if and only if state is DONE, for exactly one cycle per operation.
REQ-020 SHALL move from DONE to IDLE on the next edge if start is low; if start is high, it SHALL move to RUN, allowing back-to-back operations with no idle cycle.
REQ-021 SHALL hold Diff unchanged from one completion until the next completion.
REQ-022 SHALL use a bit counter of $clog2(INPUT_WIDTH+1) bits that never wraps within an operation.

Reset
REQ-023 SHALL, on rst high, immediately set state=IDLE, Diff=0, busy=0, done=0, borrow=0 and counter=0.
REQ-024 SHALL abort any in-flight operation on reset mid-RUN, with no done pulse and Diff=0.
REQ-025 SHALL ignore start at any edge where rst is high.

Structure
REQ-026 SHALL take its FSM state enum (IDLE/RUN/DONE) from shared package sub_pkg.
REQ-027 SHALL instantiate one combinational sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), for the bit cell.
REQ-028 SHALL keep all other state (shift registers, counter, borrow, Diff) in serial_subtractor.

Verification (INPUT_WIDTH=4)
REQ-029 Bench SHALL cover: A=9, B=3, start pulse -> busy for 4 cycles, done pulse, Diff=5'b00110.
REQ-030 Bench SHALL cover: A=3, B=9 -> Diff=5'b11010 (-6); A=0, B=15 -> Diff=5'b10001; A=15, B=0 -> Diff=5'b01111; A=B=7 -> Diff=0.
REQ-031 Bench SHALL cover: start re-asserted with A=1, B=2 while busy -> ignored; the first result still completes on schedule with its original value.
REQ-032 Bench SHALL cover: start held high in the DONE cycle with new operands -> immediate RUN, second done exactly 5 cycles after the first.
REQ-033 Bench SHALL cover: rst asserted mid-RUN (asynchronously, between edges) -> outputs zero at once, no done pulse, next operation correct.
REQ-034 Bench SHALL cover: exhaustive sweep of all 256 A/B pairs checked against the reference {1'b0,A}-{1'b0,B}.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types for the serial subtractor: FSM state encoding and the
// one-bit borrow-subtract equation used by the bit cell.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sub_state_e;

  // Returns {bout, d} for a single bit of a - b - bin.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor
  import sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic [1:0] cell_s;

  // Bit-cell evaluation through the shared package equation.
  always_comb begin
    cell_s = fs_bit(a, b, bin);
    d      = cell_s[0];
    bout   = cell_s[1];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B computed LSB first, one bit per clock,
// with a (INPUT_WIDTH+1)-bit two's-complement result whose MSB is the final borrow.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int INPUT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] A,
  input  logic [INPUT_WIDTH-1:0] B,
  output logic [INPUT_WIDTH:0]   Diff,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(INPUT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(INPUT_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sub_state_e             state_q, state_d;
  logic [INPUT_WIDTH-1:0] a_q, a_d;
  logic [INPUT_WIDTH-1:0] b_q, b_d;
  logic [INPUT_WIDTH-1:0] res_q, res_d;
  logic                   borrow_q, borrow_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [INPUT_WIDTH:0]   diff_q, diff_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   d_s;
  logic                   bout_s;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_s),
    .bout (bout_s)
  );

  // Next-state logic: operand load, per-bit shift and result capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so that after INPUT_WIDTH shifts
        // bit 0 holds the first (LSB) difference bit.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = (res_q >> 1) | {d_s, {(INPUT_WIDTH-1){1'b0}}};
        borrow_d = bout_s;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          diff_d  = {bout_s, res_d};
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Diff = diff_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at INPUT_WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W:0]   Diff;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   diff;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  serial_subtractor #(.INPUT_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation: start pulse, W busy cycles, done pulse, then idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_diff"}, {27'd0, Diff}, {27'd0, exp});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_diff_hold"}, {27'd0, Diff}, {27'd0, exp});
  endtask

  initial begin
    logic [W:0] e;

    vecs[0] = '{a: 4'd9,  b: 4'd3,  diff: 5'b00110};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  diff: 5'b11010};
    vecs[2] = '{a: 4'd0,  b: 4'd15, diff: 5'b10001};
    vecs[3] = '{a: 4'd15, b: 4'd0,  diff: 5'b01111};
    vecs[4] = '{a: 4'd7,  b: 4'd7,  diff: 5'b00000};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    chk("reset_diff", {27'd0, Diff}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff);
    end

    // Start re-asserted mid-RUN must not disturb the running operation.
    @(negedge clk);
    start = 1'b1; A = 4'd9; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd2;
    chk("ign_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy3", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("ign_busy4", {31'd0, busy}, 32'd1);
    chk("ign_nodone", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_diff", {27'd0, Diff}, {27'd0, 5'b00110});
    @(negedge clk);
    chk("ign_after_done", {31'd0, done}, 32'd0);
    chk("ign_after_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    start = 1'b1; A = 4'd12; B = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("b2b_busy_a", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_diff1", {27'd0, Diff}, {27'd0, 5'b00111});
    start = 1'b1; A = 4'd2; B = 4'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("b2b_busy_b", {31'd0, busy}, 32'd1);
      chk("b2b_nodone_b", {31'd0, done}, 32'd0);
      chk("b2b_diff_held", {27'd0, Diff}, {27'd0, 5'b00111});
      @(negedge clk);
    end
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_diff2", {27'd0, Diff}, {27'd0, 5'b11100});
    @(negedge clk);
    chk("b2b_done2_pulse", {31'd0, done}, 32'd0);

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    start = 1'b1; A = 4'd9; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_diff", {27'd0, Diff}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_start_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("arst_no_done", {31'd0, done}, 32'd0);
      chk("arst_no_busy", {31'd0, busy}, 32'd0);
    end
    run_op("post_rst", 4'd6, 4'd1, 5'b00101);

    // Exhaustive sweep against the unsigned reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        run_op($sformatf("sweep_%0d_%0d", a, b), 4'(a), 4'(b), e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
